// File: rtl/spi_slave_phy_if.sv
// Signal bundle between an SPI slave PHY and its surroundings: the four SPI
// pins plus the byte-side channel.
//
// Byte-side handshake (there is no valid/ready pair): tx_byte is sampled by
// the PHY only at frame start and at each byte boundary. byte_finished toggles
// once per received byte, and rx_byte is already valid in the cycle the toggle
// appears. A consumer detects a new byte by XOR-ing byte_finished with its own
// previous copy. The consumer cannot stall the PHY.
interface spi_slave_phy_if;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       byte_finished;
    logic       frame_active;
    logic       frame_error;
    logic [2:0] dbg_bit_cnt;

    // Host pins, byte source and byte consumer
    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_byte,
        input  spi_miso, rx_byte, byte_finished, frame_active, frame_error,
        input  dbg_bit_cnt
    );

    // The PHY itself
    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_byte,
        output spi_miso, rx_byte, byte_finished, frame_active, frame_error,
        output dbg_bit_cnt
    );
endinterface

// File: rtl/spi_slave_phy.sv
// SPI slave physical layer: mode 0, MSB first, 8-bit bytes.
// The SPI pins are oversampled by clk, which must run at least 4x spi_sclk.
// All SPI inputs pass through 2-flop synchronizers. sclk and cs_n also have a
// third stage so that their edges can be detected.
module spi_slave_phy (
    input  logic             clk,
    input  logic             rst_n,
    spi_slave_phy_if.slave   bus
);
    // Bit 0 is the first synchronizer stage, bit 1 the synchronized value,
    // and bit 2 the previous synchronized value (used for edge detection).
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] cs_sync_q,   cs_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    logic [2:0] bit_cnt_q,       bit_cnt_d;
    logic [7:0] rx_shift_q,      rx_shift_d;
    logic [7:0] tx_shift_q,      tx_shift_d;
    logic [7:0] rx_byte_q,       rx_byte_d;
    logic       byte_finished_q, byte_finished_d;
    logic       miso_q,          miso_d;
    logic       frame_active_q,  frame_active_d;
    logic       frame_error_q,   frame_error_d;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign mosi_s    = mosi_sync_q[1];

    // Next-state logic. Chip-select edges take priority over sclk edges, so an
    // sclk edge detected in the same cycle as deselect is dropped.
    always_comb begin
        sclk_sync_d     = {sclk_sync_q[1:0], bus.spi_sclk};
        cs_sync_d       = {cs_sync_q[1:0], bus.spi_cs_n};
        mosi_sync_d     = {mosi_sync_q[0], bus.spi_mosi};
        bit_cnt_d       = bit_cnt_q;
        rx_shift_d      = rx_shift_q;
        tx_shift_d      = tx_shift_q;
        rx_byte_d       = rx_byte_q;
        byte_finished_d = byte_finished_q;
        miso_d          = miso_q;
        frame_active_d  = frame_active_q;
        frame_error_d   = 1'b0;

        if (cs_fall) begin
            // Frame start: present the first bit of tx_byte before the first sclk edge.
            bit_cnt_d      = 3'd0;
            tx_shift_d     = bus.tx_byte;
            miso_d         = bus.tx_byte[7];
            frame_active_d = 1'b1;
        end else if (cs_rise) begin
            // Deselect: a partially received byte is discarded and flagged.
            frame_active_d = 1'b0;
            bit_cnt_d      = 3'd0;
            miso_d         = 1'b0;
            frame_error_d  = (bit_cnt_q != 3'd0);
        end else if (frame_active_q) begin
            if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[6:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_d       = {rx_shift_q[6:0], mosi_s};
                    byte_finished_d = ~byte_finished_q;
                end
            end else if (sclk_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    // Byte boundary: the only point inside a frame where tx_byte is sampled.
                    tx_shift_d = bus.tx_byte;
                    miso_d     = bus.tx_byte[7];
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    miso_d     = tx_shift_q[6];
                end
            end
        end
    end

    // State registers; synchronizers reset to the idle bus pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q     <= 3'b000;
            cs_sync_q       <= 3'b111;
            mosi_sync_q     <= 2'b00;
            bit_cnt_q       <= 3'd0;
            rx_shift_q      <= 8'h00;
            tx_shift_q      <= 8'h00;
            rx_byte_q       <= 8'h00;
            byte_finished_q <= 1'b0;
            miso_q          <= 1'b0;
            frame_active_q  <= 1'b0;
            frame_error_q   <= 1'b0;
        end else begin
            sclk_sync_q     <= sclk_sync_d;
            cs_sync_q       <= cs_sync_d;
            mosi_sync_q     <= mosi_sync_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_shift_q      <= rx_shift_d;
            tx_shift_q      <= tx_shift_d;
            rx_byte_q       <= rx_byte_d;
            byte_finished_q <= byte_finished_d;
            miso_q          <= miso_d;
            frame_active_q  <= frame_active_d;
            frame_error_q   <= frame_error_d;
        end
    end

    assign bus.spi_miso      = miso_q;
    assign bus.rx_byte       = rx_byte_q;
    assign bus.byte_finished = byte_finished_q;
    assign bus.frame_active  = frame_active_q;
    assign bus.frame_error   = frame_error_q;
    assign bus.dbg_bit_cnt   = bit_cnt_q;
endmodule

// File: tb/tb_spi_slave_phy.sv
// Directed bench for spi_slave_phy: a mode-0 host model runs sclk at 1/8 of
// clk, and expected values are hand-computed from the host's point of view.
module tb_spi_slave_phy;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    spi_slave_phy_if bus_if();

    spi_slave_phy dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: count byte_finished toggles and frame_error pulses and widths
    int   bf_toggles = 0;
    logic bf_prev    = 1'b0;
    int   fe_pulses  = 0;
    int   fe_run     = 0;
    int   fe_maxw    = 0;
    always @(negedge clk) begin
        if (bus_if.byte_finished !== bf_prev) bf_toggles++;
        bf_prev = bus_if.byte_finished;
        if (bus_if.frame_error === 1'b1) begin
            fe_run++;
        end else begin
            if (fe_run > 0) begin
                fe_pulses++;
                if (fe_run > fe_maxw) fe_maxw = fe_run;
            end
            fe_run = 0;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.spi_cs_n = 1'b1;
        bus_if.spi_sclk = 1'b0;
        bus_if.spi_mosi = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
    endtask

    // Host driver: shifts nbits of mosi_byte MSB first and samples miso as sclk
    // rises. After bit index mid_bit tx_byte is changed to mid_tx. lat returns
    // the number of clk rising edges from the raw 8th sclk rise to the
    // byte_finished toggle (0 if not seen).
    task automatic spi_xfer(input logic [7:0] mosi_byte, input int nbits,
                            input int mid_bit, input logic [7:0] mid_tx,
                            output logic [7:0] miso_byte, output int lat);
        logic bf_start;
        miso_byte = 8'h00;
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            bus_if.spi_mosi = mosi_byte[7-i];
            wait_clks(4);
            bus_if.spi_sclk = 1'b1;
            miso_byte = {miso_byte[6:0], bus_if.spi_miso};
            bf_start = bus_if.byte_finished;
            for (int c = 1; c <= 4; c++) begin
                @(posedge clk);
                #1;
                if (lat == 0 && i == 7 && bus_if.byte_finished !== bf_start) lat = c;
            end
            if (i == mid_bit) bus_if.tx_byte = mid_tx;
            @(negedge clk);
            bus_if.spi_sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.spi_cs_n = 1'b1;
        bus_if.spi_sclk = 1'b0;
        bus_if.spi_mosi = 1'b0;
        bus_if.tx_byte  = 8'h00;
        wait_clks(3);
        n_checks++; if (bus_if.rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte: got %h expected 00", bus_if.rx_byte); end
        n_checks++; if (bus_if.byte_finished !== 1'b0) begin n_fail++; $display("FAIL reset_byte_finished: got %b expected 0", bus_if.byte_finished); end
        n_checks++; if (bus_if.spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", bus_if.spi_miso); end
        n_checks++; if (bus_if.frame_active !== 1'b0) begin n_fail++; $display("FAIL reset_frame_active: got %b expected 0", bus_if.frame_active); end
        n_checks++; if (bus_if.frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b expected 0", bus_if.frame_error); end
        n_checks++; if (bus_if.dbg_bit_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d expected 0", bus_if.dbg_bit_cnt); end
        rst_n = 1'b1;
        wait_clks(3);
    endtask

    task automatic test_single_byte();
        logic [7:0] host_rx;
        int lat, tog0, fe0;
        bus_if.tx_byte = 8'h3C;
        tog0 = bf_toggles;
        fe0  = fe_pulses;
        bus_if.spi_cs_n = 1'b0;
        wait_clks(4);
        n_checks++; if (bus_if.frame_active !== 1'b1) begin n_fail++; $display("FAIL single_frame_active: got %b expected 1", bus_if.frame_active); end
        n_checks++; if (bus_if.spi_miso !== 1'b0) begin n_fail++; $display("FAIL single_first_miso: got %b expected 0", bus_if.spi_miso); end
        spi_xfer(8'hA5, 8, -1, 8'h00, host_rx, lat);
        n_checks++; if (bus_if.rx_byte !== 8'hA5) begin n_fail++; $display("FAIL single_rx_byte: got %h expected a5", bus_if.rx_byte); end
        n_checks++; if (bus_if.byte_finished !== 1'b1) begin n_fail++; $display("FAIL single_byte_finished: got %b expected 1", bus_if.byte_finished); end
        n_checks++; if (host_rx !== 8'h3C) begin n_fail++; $display("FAIL single_miso_byte: got %h expected 3c", host_rx); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL latency: got %0d edges expected 3", lat); end
        bus_if.spi_cs_n = 1'b1;
        wait_clks(6);
        n_checks++; if (bf_toggles - tog0 !== 1) begin n_fail++; $display("FAIL single_toggles: got %0d expected 1", bf_toggles - tog0); end
        n_checks++; if (bus_if.frame_active !== 1'b0) begin n_fail++; $display("FAIL single_end_frame_active: got %b expected 0", bus_if.frame_active); end
        n_checks++; if (bus_if.spi_miso !== 1'b0) begin n_fail++; $display("FAIL single_idle_miso: got %b expected 0", bus_if.spi_miso); end
        n_checks++; if (fe_pulses - fe0 !== 0) begin n_fail++; $display("FAIL single_no_error: got %0d pulses expected 0", fe_pulses - fe0); end
    endtask

    task automatic test_multi_byte();
        logic [7:0] bytes [4];
        logic [7:0] host_rx;
        logic [31:0] cmd;
        int lat, tog0;
        bytes[0] = 8'h01; bytes[1] = 8'h00; bytes[2] = 8'h12; bytes[3] = 8'h34;
        do_reset();
        tog0 = bf_toggles;
        cmd = 32'h0;
        bus_if.tx_byte = 8'h5A;
        bus_if.spi_cs_n = 1'b0;
        wait_clks(4);
        for (int b = 0; b < 4; b++) begin
            spi_xfer(bytes[b], 8, -1, 8'h00, host_rx, lat);
            cmd = {cmd[23:0], bus_if.rx_byte};
            n_checks++; if (bus_if.rx_byte !== bytes[b]) begin n_fail++; $display("FAIL multi_rx_byte[%0d]: got %h expected %h", b, bus_if.rx_byte, bytes[b]); end
            n_checks++; if (host_rx !== 8'h5A) begin n_fail++; $display("FAIL multi_miso[%0d]: got %h expected 5a", b, host_rx); end
        end
        bus_if.spi_cs_n = 1'b1;
        wait_clks(6);
        n_checks++; if (bf_toggles - tog0 !== 4) begin n_fail++; $display("FAIL multi_toggles: got %0d expected 4", bf_toggles - tog0); end
        n_checks++; if (bus_if.byte_finished !== 1'b0) begin n_fail++; $display("FAIL multi_final_bf: got %b expected 0", bus_if.byte_finished); end
        n_checks++; if (cmd !== 32'h01001234) begin n_fail++; $display("FAIL multi_cmd_word: got %h expected 01001234", cmd); end
    endtask

    task automatic test_partial_byte();
        logic [7:0] host_rx;
        logic [7:0] rx0;
        logic bf0;
        int lat, tog0, fe0;
        rx0  = bus_if.rx_byte;
        bf0  = bus_if.byte_finished;
        tog0 = bf_toggles;
        fe0  = fe_pulses;
        bus_if.spi_cs_n = 1'b0;
        wait_clks(4);
        spi_xfer(8'b1011_0000, 5, -1, 8'h00, host_rx, lat);
        bus_if.spi_cs_n = 1'b1;
        wait_clks(6);
        n_checks++; if (fe_pulses - fe0 !== 1) begin n_fail++; $display("FAIL partial_error_pulses: got %0d expected 1", fe_pulses - fe0); end
        n_checks++; if (fe_maxw !== 1) begin n_fail++; $display("FAIL partial_error_width: got %0d cycles expected 1", fe_maxw); end
        n_checks++; if (bus_if.rx_byte !== rx0) begin n_fail++; $display("FAIL partial_rx_kept: got %h expected %h", bus_if.rx_byte, rx0); end
        n_checks++; if (bus_if.byte_finished !== bf0) begin n_fail++; $display("FAIL partial_bf_kept: got %b expected %b", bus_if.byte_finished, bf0); end
        bus_if.spi_cs_n = 1'b0;
        wait_clks(4);
        spi_xfer(8'hFF, 8, -1, 8'h00, host_rx, lat);
        bus_if.spi_cs_n = 1'b1;
        wait_clks(6);
        n_checks++; if (bus_if.rx_byte !== 8'hFF) begin n_fail++; $display("FAIL partial_next_rx: got %h expected ff", bus_if.rx_byte); end
        n_checks++; if (bf_toggles - tog0 !== 1) begin n_fail++; $display("FAIL partial_next_toggles: got %0d expected 1", bf_toggles - tog0); end
    endtask

    task automatic test_tx_change();
        logic [7:0] host_rx;
        int lat;
        bus_if.tx_byte = 8'h55;
        bus_if.spi_cs_n = 1'b0;
        wait_clks(4);
        spi_xfer(8'h00, 8, 3, 8'hAA, host_rx, lat);
        n_checks++; if (host_rx !== 8'h55) begin n_fail++; $display("FAIL txchg_first: got %h expected 55", host_rx); end
        spi_xfer(8'h00, 8, -1, 8'h00, host_rx, lat);
        n_checks++; if (host_rx !== 8'hAA) begin n_fail++; $display("FAIL txchg_second: got %h expected aa", host_rx); end
        bus_if.spi_cs_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] host_rx;
        int lat, tog0, fe0;
        fe0 = fe_pulses;
        bus_if.tx_byte = 8'h00;
        bus_if.spi_cs_n = 1'b0;
        wait_clks(4);
        spi_xfer(8'hF0, 4, -1, 8'h00, host_rx, lat);
        rst_n = 1'b0;
        wait_clks(2);
        n_checks++; if (bus_if.frame_active !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_active: got %b expected 0", bus_if.frame_active); end
        n_checks++; if (bus_if.rx_byte !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_byte: got %h expected 00", bus_if.rx_byte); end
        n_checks++; if (bus_if.byte_finished !== 1'b0) begin n_fail++; $display("FAIL midrst_bf: got %b expected 0", bus_if.byte_finished); end
        n_checks++; if (bus_if.dbg_bit_cnt !== 3'd0) begin n_fail++; $display("FAIL midrst_bit_cnt: got %0d expected 0", bus_if.dbg_bit_cnt); end
        rst_n = 1'b1;
        wait_clks(4);
        n_checks++; if (bus_if.frame_active !== 1'b1) begin n_fail++; $display("FAIL midrst_restart: got %b expected 1", bus_if.frame_active); end
        tog0 = bf_toggles;
        spi_xfer(8'hC3, 8, -1, 8'h00, host_rx, lat);
        bus_if.spi_cs_n = 1'b1;
        wait_clks(6);
        n_checks++; if (bus_if.rx_byte !== 8'hC3) begin n_fail++; $display("FAIL midrst_rx: got %h expected c3", bus_if.rx_byte); end
        n_checks++; if (bf_toggles - tog0 !== 1) begin n_fail++; $display("FAIL midrst_toggles: got %0d expected 1", bf_toggles - tog0); end
        n_checks++; if (fe_pulses - fe0 !== 0) begin n_fail++; $display("FAIL midrst_no_error: got %0d pulses expected 0", fe_pulses - fe0); end
    endtask

    task automatic test_idle_sclk();
        logic [7:0] host_rx;
        logic [7:0] rx0;
        int lat, tog0;
        rx0  = bus_if.rx_byte;
        tog0 = bf_toggles;
        bus_if.tx_byte = 8'hFF;
        spi_xfer(8'h5A, 8, -1, 8'h00, host_rx, lat);
        wait_clks(4);
        n_checks++; if (bf_toggles - tog0 !== 0) begin n_fail++; $display("FAIL idle_toggles: got %0d expected 0", bf_toggles - tog0); end
        n_checks++; if (bus_if.rx_byte !== rx0) begin n_fail++; $display("FAIL idle_rx_kept: got %h expected %h", bus_if.rx_byte, rx0); end
        n_checks++; if (host_rx !== 8'h00) begin n_fail++; $display("FAIL idle_miso: got %h expected 00", host_rx); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.spi_cs_n = 1'b1;
        bus_if.spi_sclk = 1'b0;
        bus_if.spi_mosi = 1'b0;
        bus_if.tx_byte  = 8'h00;
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_partial_byte();
        test_tx_change();
        test_reset_mid_frame();
        test_idle_sclk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_phy.md
SPI_SLAVE_PHY -- requirements
Module: spi_slave_phy

Interface
REQ-001 Parameter: none; the block is fixed to SPI mode 0, MSB first, 8-bit bytes.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 spi_sclk  in  1  SPI clock from host; asynchronous to clk; idles low.
REQ-006 spi_cs_n  in  1  SPI chip select from host; asynchronous; active low.
REQ-007 spi_mosi  in  1  SPI data from host; asynchronous.
REQ-008 spi_miso  out  1  SPI data to host; plain output, no tristate.
REQ-009 tx_byte  in  8  byte to shift out in the next byte slot.
REQ-010 rx_byte  out  8  last completely received byte.
REQ-011 byte_finished  out  1  toggles once per completed byte; consumer detects change by XOR with its previous copy.
REQ-012 frame_active  out  1  high while synchronized chip select is asserted.
REQ-013 frame_error  out  1  one-cycle pulse when chip select deasserts mid-byte.

Function
REQ-014 spi_sclk, spi_cs_n and spi_mosi SHALL each pass through a 2-flop synchronizer; sclk and cs_n SHALL have a third register for edge detection.
REQ-015 Frame start SHALL be a detected synchronized cs_n high-to-low transition: bit_cnt=0, tx shift register <= tx_byte, spi_miso <= tx_byte[7], frame_active <= 1.
REQ-016 On a detected sclk rising edge while frame_active, the block SHALL shift synchronized mosi into the LSB of rx_shift and increment 3-bit bit_cnt.
REQ-017 When bit_cnt==7 at a rising edge, the block SHALL set rx_byte <= {rx_shift[6:0], mosi_s}, toggle byte_finished, and wrap bit_cnt to 0, all in the same cycle.
REQ-018 On a detected sclk falling edge while frame_active: if bit_cnt==0, the block SHALL reload the tx shift register from tx_byte and drive bit 7; otherwise it SHALL shift left and drive the next bit on spi_miso.
REQ-019 tx_byte SHALL be sampled only at frame start and at byte-boundary falling edges; changes at other times are ignored.
REQ-020 Latency: rx_byte and byte_finished SHALL update at the 3rd clk rising edge that samples raw spi_sclk high on the 8th bit.
REQ-021 spi_miso SHALL be 0 whenever frame_active is 0.
REQ-022 Detected cs_n low-to-high SHALL clear frame_active and bit_cnt; if bit_cnt!=0, frame_error pulses for exactly one cycle; rx_byte and byte_finished are unchanged.
REQ-023 Simultaneous cs_n deassert and sclk edge detection in one cycle: deassert wins; the sclk edge is ignored.
REQ-024 sclk edges detected while frame_active==0 SHALL be ignored.
REQ-025 Correct operation is required for clk >= 4x spi_sclk frequency; behaviour below that is undefined.
REQ-026 Multi-byte frames SHALL need no gap between bytes; each byte toggles byte_finished exactly once.

Reset
REQ-027 While rst_n==0 at a clk edge: rx_byte=0x00, byte_finished=0, spi_miso=0, frame_active=0, frame_error=0, bit_cnt=0, rx_shift=0, tx shift=0.
REQ-028 Synchronizers SHALL reset to the idle pattern: sclk=0, cs_n=1, mosi=0.
REQ-029 Reset mid-frame SHALL abort the frame without frame_error; if spi_cs_n is low at release, a new frame start SHALL be detected within 3 cycles.

Verification
REQ-030 Single byte: cs_n low, send 0xA5 with tx_byte=0x3C, clk=8x sclk -> rx_byte=0xA5, byte_finished 0->1, host samples 0x3C on miso.
REQ-031 Four-byte frame 0x01,0x00,0x12,0x34, no gaps -> byte_finished toggles 4 times, ending at 0; rx_byte tracks each byte; a cmd_manager instance assembles 0x01001234.
REQ-032 Partial byte: 5 bits, then cs_n high -> frame_error single-cycle pulse; rx_byte and byte_finished unchanged; next full byte 0xFF is received correctly.
REQ-033 tx_byte changed mid-byte from 0x55 to 0xAA -> current byte shifts out 0x55, next byte shifts out 0xAA.
REQ-034 rst_n low after 4 bits for 2 cycles, cs_n held low -> outputs at reset values; new frame starts; next 8 bits 0xC3 yield rx_byte=0xC3 and one toggle.
REQ-035 Latency check: measure clk edges from raw 8th sclk rise to byte_finished toggle -> exactly 3.
